// File: rtl/cpu_seq_pkg.sv
// Shared stage encoding for the multi-cycle RV32I sequencer and the datapath units that decode it.
package cpu_seq_pkg;

    localparam int unsigned StateW = 4;

    typedef enum logic [StateW-1:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StRead   = 4'd3,
        StExec   = 4'd4,
        StMem    = 4'd5,
        StWb     = 4'd6,
        StPcUpd  = 4'd7,
        StFault  = 4'd8,
        StHalted = 4'd9
    } state_e;

    // Stages that wait on a memory handshake and therefore run the timeout counter.
    function automatic logic is_wait_state(state_e s);
        return (s == StFetch) || (s == StMem);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Clearable saturating counter of unacknowledged memory-request cycles; flags when WAIT_MAX is reached.
module seq_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic limit_hit_o
);

    localparam int unsigned CntW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CntW-1:0] Limit = CntW'(WAIT_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit_o = (cnt_q == Limit);

endmodule

// File: rtl/cpu_sequencer.sv
// Central control FSM stepping the shared datapath through fetch..PC update with memory stall timeout.
// Optional single-step/halt debug support is enabled by defining CPU_SEQ_DEBUG_EN.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic             rd_en_i,
    input  logic             taken_branch_i,
    output logic [3:0]       state_o,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instr_count_o,
`ifdef CPU_SEQ_DEBUG_EN
    input  logic             halt_req_i,
    input  logic             step_i,
    output logic             halted_o,
`endif
    output logic             fault_o
);

    state_e           state_q, state_d;
    logic             pc_sel_q, pc_sel_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             limit_hit;
    logic             wait_inc;

    assign wait_inc = ((state_q == StFetch) && !imem_ready_i) ||
                      ((state_q == StMem) && !dmem_ready_i);

    // Counter is held at zero outside FETCH/MEM, so it starts from zero on every entry.
    seq_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (!is_wait_state(state_q)),
        .inc_i       (wait_inc),
        .limit_hit_o (limit_hit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch: begin
                if (imem_ready_i) begin
                    state_d = StDecode;
                end else if (limit_hit) begin
                    state_d = StFault;
                end
            end
            StDecode: state_d = StRead;
            StRead:   state_d = StExec;
            StExec: begin
                if (is_load_i || is_store_i) begin
                    state_d = StMem;
                end else if (rd_en_i) begin
                    state_d = StWb;
                end else begin
                    state_d = StPcUpd;
                end
            end
            StMem: begin
                if (dmem_ready_i) begin
                    state_d = (is_load_i && rd_en_i) ? StWb : StPcUpd;
                end else if (limit_hit) begin
                    state_d = StFault;
                end
            end
            StWb:     state_d = StPcUpd;
`ifdef CPU_SEQ_DEBUG_EN
            StPcUpd:  state_d = halt_req_i ? StHalted : StFetch;
            StHalted: begin
                if (step_i || !halt_req_i) begin
                    state_d = StFetch;
                end
            end
`else
            StPcUpd:  state_d = StFetch;
            StHalted: state_d = StFetch;
`endif
            StFault:  state_d = StFault;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_sel_d = pc_sel_q;
        count_d  = count_q;
        if (state_q == StExec) begin
            pc_sel_d = taken_branch_i;
        end
        if (state_q == StPcUpd) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            pc_sel_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_sel_q <= pc_sel_d;
            count_q  <= count_d;
        end
    end

    assign state_o       = state_q;
    assign imem_req_o    = (state_q == StFetch);
    assign dmem_req_o    = (state_q == StMem);
    assign rf_we_o       = (state_q == StWb);
    assign pc_we_o       = (state_q == StPcUpd);
    assign retire_o      = (state_q == StPcUpd);
    assign fault_o       = (state_q == StFault);
    assign pc_sel_o      = pc_sel_q;
    assign instr_count_o = count_q;
`ifdef CPU_SEQ_DEBUG_EN
    assign halted_o      = (state_q == StHalted);
`endif

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Central control FSM for the multi-cycle RV32I core. It steps the shared datapath (imem, decode, rf, alu, dmem, branch) through fetch, decode, operand read, execute, memory, write-back and PC update. It stalls on memory handshakes, skips stages an instruction does not need, and counts retired instructions. It replaces the free-running modulo-7 state counter. Every datapath unit consumes its `state` output.

## Interface
- `WAIT_MAX`, default 15: maximum cycles a memory request may stay unacknowledged before a fault.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `imem_ready` input 1: instruction memory has returned `instr`.
- `dmem_ready` input 1: data memory access complete.
- `is_load` input 1: decoded load.
- `is_store` input 1: decoded store.
- `rd_en` input 1: instruction writes `rd`.
- `taken_branch` input 1: branch unit selects the target address.
- `state` output 4: current stage encoding; the datapath units decode this.
- `imem_req` output 1: fetch request.
- `dmem_req` output 1: data request.
- `rf_we` output 1: register-file write strobe.
- `pc_we` output 1: PC update strobe.
- `pc_sel` output 1: 1 selects the branch/jump address, 0 selects pc+4.
- `retire` output 1: one-cycle pulse per completed instruction.
- `instr_count` output CNT_W: retired-instruction counter.
- `fault` output 1: sticky memory-timeout flag.
- `halt_req` input 1: present only with CPU_SEQ_DEBUG_EN.
- `step` input 1: present only with CPU_SEQ_DEBUG_EN.
- `halted` output 1: present only with CPU_SEQ_DEBUG_EN.

## Operation
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, READ=3, EXEC=4, MEM=5, WB=6, PCUPD=7, FAULT=8, HALTED=9.
  - Values 1–7 keep the existing datapath stage meanings.
- Moore outputs, all decoded from the state register only:
  - `imem_req` in FETCH.
  - `dmem_req` in MEM.
  - `rf_we` in WB.
  - `pc_we` and `retire` in PCUPD.
  - `fault` in FAULT.
  - `halted` in HALTED.
- `pc_sel` = `taken_branch` registered on exiting EXEC; held until the next EXEC.
- Transitions:
  - IDLE goes to FETCH.
  - FETCH goes to DECODE when `imem_ready`=1.
  - DECODE goes to READ; READ goes to EXEC (one cycle each).
  - EXEC goes to MEM if `is_load|is_store`, else to WB if `rd_en`, else to PCUPD.
  - MEM goes, when `dmem_ready`=1, to WB if `is_load&rd_en`, else to PCUPD.
  - WB goes to PCUPD.
  - PCUPD goes to FETCH, or to HALTED under the debug rule.
  - FAULT is terminal until reset.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle the handshake `ready` is low.
  - If it reaches WAIT_MAX with `ready` still low, the next state is FAULT.
  - `ready` and the limit in the same cycle: `ready` wins.
- `instr_count` increments in PCUPD and wraps modulo 2^CNT_W silently.
- Decode flags (`is_load`, `is_store`, `rd_en`) are sampled only in EXEC and MEM. Decode holds them stable through PCUPD.

## Timing
- Reset (`reset`=0 at a rising edge): next cycle state=IDLE, `instr_count`=0, `pc_sel`=0, wait counter=0, and every output is 0. Reset overrides any in-flight stall, FAULT or HALTED.
- The first FETCH is 2 cycles after reset deasserts (the IDLE cycle, then FETCH).
- Minimum latency per instruction, with ready in the first FETCH cycle, FETCH through PCUPD:
  - ALU op with `rd`: 6 cycles.
  - Store: 6 cycles (MEM replaces WB).
  - Load: 7 cycles.
  - Branch with no `rd`: 5 cycles.
- Each stall cycle in FETCH or MEM adds 1 cycle.
- `retire` and `pc_we` are coincident single-cycle pulses. `instr_count` shows the new value the cycle after PCUPD.

## Configuration
- `CPU_SEQ_DEBUG_EN` defined:
  - `halt_req`, `step` and `halted` exist.
  - In PCUPD with `halt_req`=1, the next state is HALTED.
  - In HALTED, `step`=1 or `halt_req`=0 goes to FETCH. With `step`, exactly one instruction executes, then HALTED is re-entered if `halt_req` is still 1.
  - `halt_req` is ignored mid-instruction.
- `CPU_SEQ_DEBUG_EN` undefined: the ports are absent, HALTED is unreachable, and PCUPD always goes to FETCH.

## Structure
- Package `cpu_seq_pkg` holds the state encoding localparams, so the datapath units share one definition.
- One sub-module, `seq_wait_timer`: the clearable saturating wait counter with a `limit_hit` output, parameterised by WAIT_MAX.

## Test plan
- ALU op, ready always 1 (`rd_en`=1, no load/store): states 1,2,3,4,6,7. One `retire`; `instr_count`=1; `rf_we` high 1 cycle.
- Load with `dmem_ready` delayed 3 cycles: MEM held 4 cycles, `dmem_req` high 4 cycles, then WB, then PCUPD. Total 10 cycles.
- Branch (`rd_en`=0, `taken_branch`=1): EXEC goes to PCUPD with `pc_sel`=1 and `pc_we`=1. Next non-branch instruction: `pc_sel`=0.
- `imem_ready` held 0 for 16 cycles (WAIT_MAX=15): FAULT entered, `fault`=1 sticky. `reset`=0 gives IDLE with `fault`=0. Also `imem_ready`=1 on the 15th stall cycle: DECODE, no fault.
- `reset` asserted during a MEM stall: next cycle IDLE, `dmem_req`=0, `instr_count`=0.
- With CPU_SEQ_DEBUG_EN, `halt_req`=1: HALTED after the first instruction. A `step` pulse retires exactly one more instruction (`instr_count` 1→2) and returns to HALTED.
